// File: rtl/seq_alu.sv
// Registered RV32I-style ALU with valid/ready handshakes on both sides.
// Iterative MUL/MULHU/DIVU/REMU are compiled only when SEQ_ALU_MULDIV_EN is defined.
module seq_alu #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

`ifdef SEQ_ALU_MULDIV_EN
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
`else
    typedef enum logic [0:0] {S_IDLE, S_DONE} state_t;
`endif

    state_t           r_state;
    logic [WIDTH-1:0] r_result;

    function automatic logic [WIDTH-1:0] f_simple(input logic [3:0] fo,
                                                  input logic [WIDTH-1:0] fa,
                                                  input logic [WIDTH-1:0] fb);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic [SHW-1:0]          sh;
        sa = $signed(fa);
        sb = $signed(fb);
        sh = fb[SHW-1:0];
        case (fo)
            4'd0:    return fa + fb;
            4'd1:    return fa - fb;
            4'd2:    return fa << sh;
            4'd3:    return WIDTH'(sa < sb);
            4'd4:    return fa >> sh;
            4'd5:    return fa | fb;
            4'd6:    return fa & fb;
            4'd7:    return fb;
            4'd8:    return $unsigned(sa >>> sh);
            4'd9:    return WIDTH'(fa < fb);
            4'd10:   return fa ^ fb;
            default: return '0;
        endcase
    endfunction

`ifdef SEQ_ALU_MULDIV_EN
    // r_hi/r_lo hold the product accumulator for multiply, or remainder/quotient for divide.
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_b;
    logic [3:0]         r_op;
    logic [SHW:0]       r_cnt;
    logic               w_is_muldiv;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_macc;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_hi_nxt;
    logic [WIDTH-1:0]   w_lo_nxt;
    logic [WIDTH-1:0]   w_final;

    always_comb begin
        w_is_muldiv = (op >= 4'd11) && (op <= 4'd14);
        w_sum       = {1'b0, r_hi} + {1'b0, r_b};
        w_macc      = r_lo[0] ? {w_sum, r_lo[WIDTH-1:1]} : {1'b0, r_hi, r_lo[WIDTH-1:1]};
        w_trial     = {r_hi, r_lo[WIDTH-1]};
        w_diff      = w_trial - {1'b0, r_b};
        w_hi_nxt    = w_trial[WIDTH-1:0];
        w_lo_nxt    = {r_lo[WIDTH-2:0], 1'b0};
        if (r_op == 4'd11 || r_op == 4'd12) begin
            {w_hi_nxt, w_lo_nxt} = w_macc;
        end else if (!w_diff[WIDTH]) begin
            // No borrow: divisor fits, keep the difference and shift in a quotient 1.
            w_hi_nxt = w_diff[WIDTH-1:0];
            w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
        end
        w_final = (r_op == 4'd12 || r_op == 4'd14) ? w_hi_nxt : w_lo_nxt;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_result <= '0;
`ifdef SEQ_ALU_MULDIV_EN
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_cnt    <= '0;
`endif
        end else if (flush) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
`ifdef SEQ_ALU_MULDIV_EN
                        if (w_is_muldiv) begin
                            // Multiply shifts in2 through r_lo; divide shifts the dividend through it.
                            r_hi    <= '0;
                            r_lo    <= (op >= 4'd13) ? in1 : in2;
                            r_b     <= (op >= 4'd13) ? in2 : in1;
                            r_op    <= op;
                            r_cnt   <= (SHW+1)'(WIDTH);
                            r_state <= S_BUSY;
                        end else begin
                            r_result <= f_simple(op, in1, in2);
                            r_state  <= S_DONE;
                        end
`else
                        r_result <= f_simple(op, in1, in2);
                        r_state  <= S_DONE;
`endif
                    end
                end
`ifdef SEQ_ALU_MULDIV_EN
                S_BUSY: begin
                    r_hi  <= w_hi_nxt;
                    r_lo  <= w_lo_nxt;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == (SHW+1)'(1)) begin
                        r_result <= w_final;
                        r_state  <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    if (out_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign zero      = (r_result == '0);

endmodule

// File: tb/tb_seq_alu.sv
// Randomised scoreboard bench for seq_alu (WIDTH=32) against a plain-arithmetic reference model.
// Follows SEQ_ALU_MULDIV_EN the same way the design does.
module tb_seq_alu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = 4'd0;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;

    seq_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .in1(in1), .in2(in2),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  op;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          ready_mode = 2;  // 0 random, 1 always high, 2 held low
    bit          mon_en = 1'b1;
    logic [31:0] last_res = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        logic [63:0] p;
        sh = b % 32;
        p  = 64'(a) * 64'(b);
        case (o)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a << sh;
            4'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4:  return a >> sh;
            4'd5:  return a | b;
            4'd6:  return a & b;
            4'd7:  return b;
            4'd8:  return 32'($signed(a) >>> sh);
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
            4'd10: return a ^ b;
`ifdef SEQ_ALU_MULDIV_EN
            4'd11: return p[31:0];
            4'd12: return p[63:32];
            4'd13: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd14: return (b == 0) ? a : a % b;
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic int lat_of(input logic [3:0] o);
`ifdef SEQ_ALU_MULDIV_EN
        if (o >= 4'd11 && o <= 4'd14) return 33;
`endif
        return (o == 4'd0) ? 1 : 1;
    endfunction

    initial forever @(posedge clk) cyc++;

    initial forever begin
        @(posedge clk);
        #1;
        if (ready_mode == 0) out_ready = ($urandom_range(0, 3) != 0);
        else out_ready = (ready_mode == 1);
    end

    // Monitor: latency on each rising out_valid, value on each handshake.
    initial begin
        bit   prev_v;
        exp_t e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
            end else begin
                if (out_valid && !prev_v && mon_en) begin
                    if (sb.size() == 0) chk("spurious_out_valid", 32'(out_valid), 32'd0);
                    else chk($sformatf("latency_op%0d", sb[0].op), 32'(cyc - sb[0].acc + 1), 32'(sb[0].lat));
                end
                if (out_valid && out_ready && !flush && mon_en && sb.size() > 0) begin
                    e = sb.pop_front();
                    chk($sformatf("result_op%0d", e.op), result, e.res);
                    chk($sformatf("zero_op%0d", e.op), 32'(zero), 32'(e.res == 0));
                    last_res = result;
                end
                prev_v = out_valid;
            end
        end
    end

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input bit track);
        bit ok;
        exp_t e;
        ok = 1'b0;
        @(posedge clk);
        #1;
        op = o; in1 = a; in2 = b; in_valid = 1'b1;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (in_ready && !flush) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else if (track) begin
            e.res = model(o, a, b);
            e.op  = o;
            e.acc = cyc + 1;
            e.lat = lat_of(o);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 4'($urandom); in1 = $urandom; in2 = $urandom;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("out_valid_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit ok;
        int bad_cnt;
        logic [31:0] held;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_zero", 32'(zero), 32'd1);
        rst_n = 1'b1;
        ready_mode = 1;

        issue(4'd0, 32'hFFFF_FFFF, 32'd2, 1'b1);
        issue(4'd1, 32'd5, 32'd5, 1'b1);
        issue(4'd8, 32'h8000_0000, 32'h24, 1'b1);
        issue(4'd3, 32'hFFFF_FFFF, 32'd1, 1'b1);
        issue(4'd9, 32'hFFFF_FFFF, 32'd1, 1'b1);
        issue(4'd10, 32'hF0F0_1234, 32'h0FF0_1234, 1'b1);
        issue(4'd15, 32'd7, 32'd9, 1'b1);
        issue(4'd11, 32'h0001_0000, 32'h0001_0000, 1'b1);
`ifdef SEQ_ALU_MULDIV_EN
        bad_cnt = 0;
        for (int k = 0; k < 40 && !out_valid; k++) begin
            if (in_ready) bad_cnt++;
            @(negedge clk);
        end
        chk("busy_in_ready_low_violations", 32'(bad_cnt), 32'd0);
`endif
        issue(4'd12, 32'h0001_0000, 32'h0001_0000, 1'b1);
        issue(4'd13, 32'd100, 32'd7, 1'b1);
        issue(4'd14, 32'd100, 32'd7, 1'b1);
        issue(4'd13, 32'hDEAD_BEEF, 32'd0, 1'b1);
        issue(4'd14, 32'h0000_1234, 32'd0, 1'b1);
        issue(4'd11, 32'd3, 32'd4, 1'b1);

        // Consumer stall: result and handshake must hold.
        @(negedge clk);
        ready_mode = 2;
        issue(4'd0, 32'd1, 32'd2, 1'b1);
        wait_valid(ok);
        if (ok) begin
            held = result;
            repeat (5) begin
                chk("stall_result", result, 32'd3);
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                chk("stall_out_valid", 32'(out_valid), 32'd1);
                @(negedge clk);
            end
            ready_mode = 1;
            repeat (2) @(negedge clk);
            chk("stall_release_in_ready", 32'(in_ready), 32'd1);
            chk("stall_release_result", result, held);
        end

`ifdef SEQ_ALU_MULDIV_EN
        // Flush ten cycles into a divide.
        mon_en = 1'b0;
        held = result;
        issue(4'd13, 32'd1000, 32'd3, 1'b0);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_result_kept", result, held);
        bad_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) bad_cnt++;
        end
        chk("flush_out_valid_never", 32'(bad_cnt), 32'd0);

        // Asynchronous reset in the middle of a multiply.
        issue(4'd11, 32'd7, 32'd9, 1'b0);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy_result", result, 32'd0);
        chk("rst_busy_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
`else
        // Flush while a result waits in DONE.
        mon_en = 1'b0;
        @(negedge clk);
        ready_mode = 2;
        issue(4'd0, 32'd40, 32'd2, 1'b0);
        wait_valid(ok);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_result_kept", result, 32'd42);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        ready_mode = 1;
        rst_n = 1'b0;
        #1;
        chk("rst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
`endif

        // Randomised traffic with a random consumer.
        @(negedge clk);
        ready_mode = 0;
        for (int i = 0; i < 150; i++) begin
            issue(4'($urandom_range(0, 15)), pick(), pick(), 1'b1);
        end
        @(negedge clk);
        ready_mode = 1;
        for (int k = 0; k < 2000 && sb.size() > 0; k++) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
